// File: rtl/fifo_pkg.sv
// Shared types for the FIFO reader: byte type, buffer occupancy encoding
// and a helper that turns an occupancy state into a plain count.
package fifo_pkg;

   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] byte_t;

   // Occupancy of the 2-entry output buffer.
   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } rd_occ_e;

   // Number of bytes held for a given occupancy state.
   function automatic logic [1:0] occ_to_count(input rd_occ_e s);
      logic [1:0] n;
      case (s)
         S0:      n = 2'd0;
         S1:      n = 2'd1;
         S2:      n = 2'd2;
         default: n = 2'd2;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// Bundle of the FIFO-side and stream-side signals of the FIFO reader.
// master: the reader itself. slave: the FIFO plus the downstream sink.
// Optional FIFO_READER_COUNT_EN adds the delivered-byte counter.
interface fifo_reader_if #(
   parameter int DATA_W = 8
`ifdef FIFO_READER_COUNT_EN
   , parameter int CNT_W = 16
`endif
);

   logic              in_is_empty;
   logic [DATA_W-1:0] in_read_data;
   logic              out_read_ctrl;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              in_ready;
`ifdef FIFO_READER_COUNT_EN
   logic [CNT_W-1:0]  out_byte_count;
`endif

   modport master (
      input  in_is_empty,
      input  in_read_data,
      input  in_ready,
      output out_read_ctrl,
      output out_valid,
      output out_data
`ifdef FIFO_READER_COUNT_EN
      , output out_byte_count
`endif
   );

   modport slave (
      output in_is_empty,
      output in_read_data,
      output in_ready,
      input  out_read_ctrl,
      input  out_valid,
      input  out_data
`ifdef FIFO_READER_COUNT_EN
      , input  out_byte_count
`endif
   );

endinterface

// File: rtl/fifo_reader_skid_buf.sv
// Two-entry output buffer of the FIFO reader. Bytes arriving from the FIFO
// are written at the tail on capture and leave from the head on accept.
// The head entry drives the stream data directly, so it only changes when
// the head is consumed.
module reader_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_W = fifo_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic [DATA_W-1:0] capture_data,
   input  logic              accept,
   output rd_occ_e           occ,
   output logic              valid,
   output logic [DATA_W-1:0] head_data
);

   logic [DATA_W-1:0] entry [2];
   logic              head_reg;
   logic              head_next;
   logic              tail_reg;
   logic              tail_next;
   rd_occ_e           occ_reg;
   rd_occ_e           occ_next;
   logic              valid_reg;

   // Next occupancy and pointer movement from the capture/accept pair.
   always_comb begin
      occ_next  = occ_reg;
      head_next = head_reg;
      tail_next = tail_reg;
      if (capture) begin
         tail_next = ~tail_reg;
      end
      if (accept) begin
         head_next = ~head_reg;
      end
      case ({capture, accept})
         2'b10:   occ_next = (occ_reg == S0) ? S1 : S2;
         2'b01:   occ_next = (occ_reg == S2) ? S1 : S0;
         default: occ_next = occ_reg;
      endcase
   end

   // Occupancy, pointers and the registered valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_reg   <= S0;
         head_reg  <= 1'b0;
         tail_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         occ_reg   <= occ_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         valid_reg <= (occ_next != S0);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [DATA_W-1:0] entry_reg;

         // Storage slot; written only when it is the tail at capture time.
         always_ff @(posedge clk) begin
            if (rst) begin
               entry_reg <= '0;
            end else if (capture && (tail_reg == 1'(gi))) begin
               entry_reg <= capture_data;
            end
         end

         assign entry[gi] = entry_reg;
      end
   endgenerate

   assign occ       = occ_reg;
   assign valid     = valid_reg;
   assign head_data = entry[head_reg];

   // A capture into a full buffer would lose a byte; the pop gating upstream
   // must make this impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      (capture && !accept) |-> (occ_reg != S2));

   // The sink can only accept while something is held.
   a_no_underflow : assert property (@(posedge clk) disable iff (rst)
      accept |-> (occ_reg != S0));

endmodule

// File: rtl/fifo_reader.sv
// FIFO reader top: pops bytes from a registered-read FIFO and presents them
// on a valid/ready stream. A pop is issued only if the byte it fetches is
// guaranteed a slot in the 2-entry buffer once it arrives one cycle later.
// Optional feature macro: FIFO_READER_COUNT_EN (delivered-byte counter).
module fifo_reader
   import fifo_pkg::*;
#(
   parameter int DATA_W = fifo_pkg::DATA_W,
   parameter int CNT_W  = 16
) (
   input logic           clk,
   input logic           rst,
   fifo_reader_if.master bus
);

   logic       pending_reg;
   logic       accept;
   logic       pop;
   rd_occ_e    occ;
   logic [2:0] committed;

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("fifo_reader: CNT_W must be at least 1");
   end

   // Bytes held or in flight after this cycle's accept; a pop is allowed
   // while that leaves room for one more.
   assign accept    = bus.out_valid & bus.in_ready;
   assign committed = {1'b0, occ_to_count(occ)} + {2'b00, pending_reg} - {2'b00, accept};
   assign pop       = !rst && !bus.in_is_empty && (committed < 3'd2);

   assign bus.out_read_ctrl = pop;

   // FIFO read data is valid the cycle after a pop; remember that it is coming.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg <= 1'b0;
      end else begin
         pending_reg <= pop;
      end
   end

   reader_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid_buf (
      .clk          (clk),
      .rst          (rst),
      .capture      (pending_reg),
      .capture_data (bus.in_read_data),
      .accept       (accept),
      .occ          (occ),
      .valid        (bus.out_valid),
      .head_data    (bus.out_data)
   );

`ifdef FIFO_READER_COUNT_EN
   logic [CNT_W-1:0] count_reg;

   // Delivered-byte counter, wrapping naturally at its width.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (accept) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign bus.out_byte_count = count_reg;
`endif

   // Popping an empty FIFO is a protocol error on the FIFO side.
   a_no_pop_when_empty : assert property (@(posedge clk) disable iff (rst)
      pop |-> !bus.in_is_empty);

endmodule

// File: tb/tb_fifo_reader.sv
// Testbench for fifo_reader: a queue-based FIFO model feeds the reader and
// a scoreboard checks that delivered bytes match the popped bytes in order,
// along with latency, backpressure, reset and (optionally) counter behaviour.
module tb_fifo_reader;
   import fifo_pkg::*;

   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

`ifdef FIFO_READER_COUNT_EN
   fifo_reader_if #(.DATA_W(8), .CNT_W(CNT_W)) bus ();
`else
   fifo_reader_if #(.DATA_W(8)) bus ();
`endif

   fifo_reader #(
      .DATA_W (8),
      .CNT_W  (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   byte_t fifo_q[$];
   byte_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    cnt_model = 0;
   int    pops_win, acc_win, valid_win;
   int    first_pop, last_pop, first_valid, last_valid;
   byte_t first_acc;
   logic  pop_s, acc_s, rst_s;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_win();
      pops_win = 0; acc_win = 0; valid_win = 0;
      first_pop = -1; last_pop = -1; first_valid = -1; last_valid = -1;
      first_acc = '0;
   endtask

   task automatic push(input byte_t b);
      fifo_q.push_back(b);
      bus.in_is_empty = 1'b0;
   endtask

   // One clock: check outputs at the falling edge, then advance the FIFO model.
   task automatic step();
      byte_t b;
      @(negedge clk);
      rst_s = rst;
      pop_s = bus.out_read_ctrl;
      acc_s = bus.out_valid & bus.in_ready;
      if (rst_s) check("pop_in_reset", pop_s, 1'b0);
      check("pop_vs_empty", pop_s && (fifo_q.size() == 0), 1'b0);
      if (bus.out_valid) begin
         valid_win++;
         if (first_valid < 0) first_valid = cyc;
         last_valid = cyc;
         if (exp_q.size() == 0) check("valid_spurious", bus.out_valid, 1'b0);
         else check("head_data", bus.out_data, exp_q[0]);
      end
      if (acc_s && exp_q.size() > 0) begin
         b = exp_q.pop_front();
         if (acc_win == 0) first_acc = b;
         acc_win++;
         $display("cyc %0d accept byte %02h", cyc, b);
      end
      if (pop_s) begin
         pops_win++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
         if (fifo_q.size() > 0) exp_q.push_back(fifo_q[0]);
      end
      check("outstanding_le2", exp_q.size() <= 2, 1'b1);
`ifdef FIFO_READER_COUNT_EN
      check("byte_count", bus.out_byte_count, 32'(cnt_model % (1 << CNT_W)));
      if (rst_s) cnt_model = 0;
      else if (acc_s) cnt_model++;
`endif
      @(posedge clk);
      #1;
      cyc++;
      if (rst_s) exp_q.delete();
      if (pop_s && fifo_q.size() > 0) bus.in_read_data = fifo_q.pop_front();
      else bus.in_read_data = byte_t'($urandom);
      bus.in_is_empty = (fifo_q.size() == 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      byte_t stream_bytes [4];
      stream_bytes[0] = 8'h11; stream_bytes[1] = 8'h22;
      stream_bytes[2] = 8'h33; stream_bytes[3] = 8'h44;
      rst = 1'b1;
      bus.in_is_empty = 1'b1;
      bus.in_read_data = '0;
      bus.in_ready = 1'b0;
      clear_win();

      // 1. Reset held 3 cycles while the FIFO reports data.
      for (int i = 0; i < 4; i++) push(stream_bytes[i]);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_valid", bus.out_valid, 1'b0);
         check("rst_data", bus.out_data, 8'h00);
         check("rst_pop", bus.out_read_ctrl, 1'b0);
      end
      rst = 1'b0;
      fifo_q.delete();
      bus.in_is_empty = 1'b1;
      run(2);

      // 2. Streaming at full rate.
      clear_win();
      bus.in_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(stream_bytes[i]);
      run(10);
      check("stream_pops", pops_win, 4);
      check("stream_pops_consecutive", last_pop - first_pop, 3);
      check("stream_latency", first_valid - first_pop, 2);
      check("stream_valid_cycles", valid_win, 4);
      check("stream_valid_consecutive", last_valid - first_valid, 3);
      check("stream_accepts", acc_win, 4);

      // 3. Backpressure: only two pops, head held, then resume in order.
      clear_win();
      bus.in_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(stream_bytes[i]);
      run(8);
      check("bp_pops", pops_win, 2);
      check("bp_head", bus.out_data, 8'h11);
      check("bp_pop_stalled", bus.out_read_ctrl, 1'b0);
      bus.in_ready = 1'b1;
      run(10);
      check("bp_accepts", acc_win, 4);
      check("bp_first", first_acc, 8'h11);

      // 4. Empty FIFO throughout.
      clear_win();
      for (int i = 0; i < 20; i++) begin
         bus.in_ready = 1'($urandom);
         step();
      end
      check("empty_pops", pops_win, 0);
      check("empty_valid", valid_win, 0);

      // 5. Reset with a byte held and another in flight.
      clear_win();
      bus.in_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(byte_t'(8'h60 + i));
      for (int i = 0; i < 10 && pops_win < 2; i++) step();
      check("midrst_pops", pops_win, 2);
      rst = 1'b1;
      step();
      check("midrst_valid", bus.out_valid, 1'b0);
      check("midrst_data", bus.out_data, 8'h00);
      rst = 1'b0;
      fifo_q.delete();
      bus.in_is_empty = 1'b1;
      push(8'hA5);
      bus.in_ready = 1'b1;
      clear_win();
      for (int i = 0; i < 10 && acc_win < 1; i++) step();
      check("midrst_accepts", acc_win, 1);
      check("midrst_first", first_acc, 8'hA5);

`ifdef FIFO_READER_COUNT_EN
      // 6. Counter wraps after 17 accepts at 4 bits.
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_win();
      for (int i = 0; i < 17; i++) push(byte_t'($urandom));
      bus.in_ready = 1'b1;
      run(25);
      check("cnt_accepts", acc_win, 17);
      check("cnt_wrap", bus.out_byte_count, 32'd1);
`endif

      // Random traffic with occasional resets, then drain.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 1) == 1 && fifo_q.size() < 8) push(byte_t'($urandom));
         bus.in_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      bus.in_ready = 1'b1;
      for (int i = 0; i < 40 && (fifo_q.size() > 0 || exp_q.size() > 0); i++) step();
      check("drain_fifo", fifo_q.size(), 0);
      check("drain_buffer", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
